fsm_cmd_tx: RTL and testbench
=============================

Name: fsm_cmd_tx

Overview:
- Transmitter end of the FSM_CMD word stream consumed by the per-voice `fsm_brain` receivers.
- Accepts one high-level request (opcode + voice mask), builds the header word, then forwards exactly the payload word count that opcode requires, in receiver order.
- Sits between the host/control-register logic and the FSM_CMD bus fanned out to all six-operator voices.
- Guarantees framing, so the receivers' word counters never desynchronise.

Parameters:
- GAP_CYCLES, 0: minimum idle cycles forced between the last word of one frame and the next header (0 = back-to-back allowed).
- SET_WORDS, 56: payload length of SET (9 groups x 6 operators + modin_1 + modin_2).
- FREQ_WORDS, 6: payload length of SET_FREQ (one per operator).

Ports:
- clk147  in  1  system clock; every port is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  4  0=NOP, 1=SET, 2=TOGGLE, 3=SET_FREQ, 4..15 illegal.
- req_voices  in  8  voice select mask, copied to header [27:20].
- pay_valid  in  1  payload word present.
- pay_ready  out  1  payload word consumed when pay_valid & pay_ready.
- pay_data  in  32  payload word.
- cmd_data  out  32  FSM_CMD data word.
- cmd_data_valid  out  1  one-cycle qualifier per word; there is no backpressure from the receivers.
- busy  out  1  high in any state other than IDLE.
- err_op  out  1  one-cycle pulse when an illegal opcode is dropped.

Behaviour:
- Reset (async assert, sync release) sets:
  - state to IDLE;
  - cmd_data to 0 and cmd_data_valid to 0;
  - remaining counter and gap counter to 0;
  - err_op to 0 and busy to 0.
- Reset mid-frame truncates the frame. Receivers must also be reset to resynchronise; this is a documented system rule, not handled here.
- States are IDLE, PAY and GAP.
- req_ready = (state==IDLE). pay_ready = (state==PAY). Both are combinational from state only, never from the valid inputs.
- Header word = {req_op, req_voices, 20'h0}.
- IDLE: on acceptance with a legal op, cmd_data <= header and cmd_data_valid <= 1 on the next edge (1-cycle latency). Then:
  - SET: remaining <= SET_WORDS, go to PAY.
  - SET_FREQ: remaining <= FREQ_WORDS, go to PAY.
  - NOP and TOGGLE: header only; go to GAP if GAP_CYCLES>0, else stay in IDLE.
- IDLE, illegal op: request is consumed, nothing is driven on cmd_*, err_op pulses 1 cycle, state stays IDLE.
- PAY: each accepted payload word is registered to cmd_data with cmd_data_valid=1 one cycle later, and remaining decrements.
  - Cycles with pay_valid=0 produce cmd_data_valid=0 and leave cmd_data holding its value. Receivers advance only on valid, so stalls are legal.
  - When the word accepted has remaining==1, leave PAY: to GAP if GAP_CYCLES>0, else to IDLE.
- GAP: count GAP_CYCLES cycles with cmd_data_valid=0, then go to IDLE.
- cmd_data_valid is high only in the cycle after a word is accepted; it is never held.
- Back-to-back with GAP_CYCLES=0: the last payload is accepted at cycle N, IDLE at N+1, so the next header can be accepted at N+1 and appears at N+2.
- Counters: remaining is 6 bits and never wraps (it leaves PAY at 1). Gap counter width is $clog2(GAP_CYCLES+1).
- req_voices==0 is legal and is transmitted unchanged (all receivers ignore it).
- Payload words are never inspected or altered.

Optional Feature:
- Macro: FSM_CMD_TX_STATS_EN.
- When defined:
  - Adds output frame_cnt [15:0]: increments when the last word of a frame is emitted (header for NOP/TOGGLE, final payload for SET/SET_FREQ) and wraps 16'hFFFF -> 0.
  - Adds output err_cnt [7:0]: increments on each err_op and saturates at 8'hFF.
  - Both counters reset to 0.
- When undefined: both ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
- TOGGLE, voices=8'h01 -> exactly one word 32'h2010_0000 with valid, 1 cycle after acceptance; busy never set when GAP_CYCLES=0.
- SET_FREQ, voices=8'h3F, payload 1..6 -> 32'h33F0_0000 then 32'h1..32'h6 on consecutive cycles; req_ready low until after the 6th word; 7th pay_valid is not accepted.
- SET with pay_valid toggled randomly -> 57 valid words total, payload order preserved, no valid on stall cycles, remaining ends at 0.
- req_op=4'h7 -> no cmd_data_valid, err_op high 1 cycle, req_ready stays 1; with STATS_EN, err_cnt=1.
- GAP_CYCLES=3, two TOGGLEs offered back-to-back -> headers separated by exactly 4 cycles; req_ready low for 3 cycles.
- rst_n asserted after the 10th SET payload word -> cmd_data_valid=0 and cmd_data=0 immediately (async); req_ready=1 after release; with STATS_EN, frame_cnt=0.

Source files
------------

// File: rtl/fsm_cmd_tx.sv
// fsm_cmd_tx: frames one host request into an FSM_CMD header plus the opcode's payload words.
// Latency: every word (header or payload) appears on cmd_data one cycle after it is accepted.
// Backpressure: req_ready only in IDLE, pay_ready only in PAY; receivers never stall the bus.
// FSM_CMD_TX_STATS_EN adds frame_cnt/err_cnt outputs.
module fsm_cmd_tx #(
    parameter int GAP_CYCLES = 0,
    parameter int SET_WORDS  = 56,
    parameter int FREQ_WORDS = 6
) (
    input  logic        clk147,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [7:0]  req_voices,
    input  logic        pay_valid,
    output logic        pay_ready,
    input  logic [31:0] pay_data,
    output logic [31:0] cmd_data,
    output logic        cmd_data_valid,
    output logic        busy,
`ifdef FSM_CMD_TX_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
`endif
    output logic        err_op
);
    localparam logic [3:0] OP_SET  = 4'd1;
    localparam logic [3:0] OP_FREQ = 4'd3;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [5:0]    SET_LEN  = 6'(SET_WORDS);
    localparam logic [5:0]    FREQ_LEN = 6'(FREQ_WORDS);
    // Loaded one short: the cycle that sees zero is itself the last idle cycle.
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, PAY, GAP} state_t;

    state_t        state, state_d, after_frame;
    logic [5:0]    remaining, remaining_d;
    logic [GW-1:0] gap_cnt, gap_cnt_d;
    logic [31:0]   cmd_data_d;
    logic          cmd_data_valid_d;
    logic          err_op_d;
    logic          req_fire, pay_fire, op_legal;

    assign req_ready   = (state == IDLE);
    assign pay_ready   = (state == PAY);
    assign busy        = (state != IDLE);
    assign req_fire    = req_valid & req_ready;
    assign pay_fire    = pay_valid & pay_ready;
    assign op_legal    = (req_op <= OP_FREQ);
    assign after_frame = (GAP_CYCLES > 0) ? GAP : IDLE;

    always_comb begin
        state_d          = state;
        remaining_d      = remaining;
        gap_cnt_d        = gap_cnt;
        cmd_data_d       = cmd_data;
        cmd_data_valid_d = 1'b0;
        err_op_d         = 1'b0;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (op_legal) begin
                        cmd_data_d       = {req_op, req_voices, 20'h0};
                        cmd_data_valid_d = 1'b1;
                        case (req_op)
                            OP_SET: begin
                                remaining_d = SET_LEN;
                                state_d     = PAY;
                            end
                            OP_FREQ: begin
                                remaining_d = FREQ_LEN;
                                state_d     = PAY;
                            end
                            default: begin
                                state_d   = after_frame;
                                gap_cnt_d = GAP_LOAD;
                            end
                        endcase
                    end else begin
                        err_op_d = 1'b1;
                    end
                end
            end
            PAY: begin
                if (pay_fire) begin
                    cmd_data_d       = pay_data;
                    cmd_data_valid_d = 1'b1;
                    remaining_d      = remaining - 6'd1;
                    if (remaining == 6'd1) begin
                        state_d   = after_frame;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            remaining      <= '0;
            gap_cnt        <= '0;
            cmd_data       <= '0;
            cmd_data_valid <= 1'b0;
            err_op         <= 1'b0;
        end else begin
            state          <= state_d;
            remaining      <= remaining_d;
            gap_cnt        <= gap_cnt_d;
            cmd_data       <= cmd_data_d;
            cmd_data_valid <= cmd_data_valid_d;
            err_op         <= err_op_d;
        end
    end

`ifdef FSM_CMD_TX_STATS_EN
    // A word that leaves the FSM outside PAY is the last word of its frame.
    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (cmd_data_valid_d && (state_d != PAY)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (err_op_d && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fsm_cmd_tx.sv
// Bench for fsm_cmd_tx: vector table, hand-written timing sequences and a randomized
// request stream scored against a word-list model built from the framing rules.
module tb_fsm_cmd_tx;
    logic        clk147 = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [7:0]  req_voices;
    logic        pay_valid, pay_ready;
    logic [31:0] pay_data, cmd_data;
    logic        cmd_data_valid, busy, err_op;

    logic        g_req_valid, g_req_ready, g_pay_ready;
    logic [3:0]  g_req_op;
    logic [7:0]  g_req_voices;
    logic [31:0] g_cmd_data;
    logic        g_cmd_data_valid, g_busy, g_err_op;
`ifdef FSM_CMD_TX_STATS_EN
    logic [15:0] frame_cnt, g_frame_cnt;
    logic [7:0]  err_cnt, g_err_cnt;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          err_seen = 0;
    int          exp_frames = 0;
    int          exp_errs = 0;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  voices;
        bit          stall;
        int          exp_n;
        logic [31:0] exp_hdr;
        int          exp_err;
    } vec_t;
    vec_t vecs[8];

    always #5 clk147 = ~clk147;

    fsm_cmd_tx dut (
        .clk147(clk147), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_voices(req_voices),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .cmd_data(cmd_data), .cmd_data_valid(cmd_data_valid), .busy(busy),
`ifdef FSM_CMD_TX_STATS_EN
        .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`endif
        .err_op(err_op)
    );

    fsm_cmd_tx #(.GAP_CYCLES(3)) dut_gap (
        .clk147(clk147), .rst_n(rst_n),
        .req_valid(g_req_valid), .req_ready(g_req_ready), .req_op(g_req_op), .req_voices(g_req_voices),
        .pay_valid(1'b0), .pay_ready(g_pay_ready), .pay_data(32'h0),
        .cmd_data(g_cmd_data), .cmd_data_valid(g_cmd_data_valid), .busy(g_busy),
`ifdef FSM_CMD_TX_STATS_EN
        .frame_cnt(g_frame_cnt), .err_cnt(g_err_cnt),
`endif
        .err_op(g_err_op)
    );

    always @(negedge clk147) begin
        if (rst_n) begin
            if (cmd_data_valid) got_q.push_back(cmd_data);
            if (err_op) err_seen++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk147);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int pay_len(input logic [3:0] op);
        return (op == 4'd1) ? 56 : (op == 4'd3) ? 6 : 0;
    endfunction

    function automatic int stream_diff();
        int d = 0;
        if (got_q.size() != exp_q.size()) return -1;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic send_req(input logic [3:0] op, input logic [7:0] v);
        int t = 0;
        req_valid  = 1'b1;
        req_op     = op;
        req_voices = v;
        while (!req_ready && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) check("req_timeout", 1, 0);
        step();
        req_valid = 1'b0;
    endtask

    task automatic send_pay(input int n, input bit stall);
        int          idx = 0;
        int          t = 0;
        logic [31:0] w = $urandom;
        bit          acc;
        while (idx < n && t < 4000) begin
            pay_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            pay_data  = pay_valid ? w : $urandom;
            acc       = pay_valid && pay_ready;
            step();
            if (acc) begin
                exp_q.push_back(w);
                idx++;
                w = $urandom;
            end
            t++;
        end
        pay_valid = 1'b0;
        if (idx < n) check("pay_timeout", idx, n);
    endtask

    task automatic run_frame(input logic [3:0] op, input logic [7:0] v, input bit stall);
        if (op <= 4'd3) begin
            exp_q.push_back({op, v, 20'h0});
            exp_frames++;
        end else begin
            exp_errs++;
        end
        send_req(op, v);
        send_pay(pay_len(op), stall);
    endtask

    initial begin
        int         r;
        logic [3:0] op;
        int         errs0;
        int         hdr_cyc[$];
        int         low;
        logic       busy_gap;

        vecs[0] = '{4'd2, 8'h01, 1'b0, 1,  32'h2010_0000, 0};
        vecs[1] = '{4'd0, 8'h00, 1'b0, 1,  32'h0000_0000, 0};
        vecs[2] = '{4'd3, 8'h3F, 1'b1, 7,  32'h33F0_0000, 0};
        vecs[3] = '{4'd1, 8'hAA, 1'b1, 57, 32'h1AA0_0000, 0};
        vecs[4] = '{4'd7, 8'h55, 1'b0, 0,  32'h0000_0000, 1};
        vecs[5] = '{4'hF, 8'hFF, 1'b0, 0,  32'h0000_0000, 1};
        vecs[6] = '{4'd2, 8'hFF, 1'b0, 1,  32'h2FF0_0000, 0};
        vecs[7] = '{4'd1, 8'h00, 1'b0, 57, 32'h1000_0000, 0};

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_voices = '0;
        pay_valid = 1'b0; pay_data = '0;
        g_req_valid = 1'b0; g_req_op = '0; g_req_voices = '0;
        repeat (3) step();
        check("rst_req_ready", req_ready, 1);
        check("rst_pay_ready", pay_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", cmd_data_valid, 0);
        check("rst_data", cmd_data, 0);
        check("rst_err_op", err_op, 0);
`ifdef FSM_CMD_TX_STATS_EN
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
`endif
        @(negedge clk147);
        rst_n = 1'b1;
        step();

        // Illegal opcode: consumed, flagged, nothing on the bus.
        req_valid = 1'b1; req_op = 4'h7; req_voices = 8'h55;
        check("ill_ready_pre", req_ready, 1);
        step();
        req_valid = 1'b0;
        exp_errs++;
        check("ill_err_op", err_op, 1);
        check("ill_valid", cmd_data_valid, 0);
        check("ill_req_ready", req_ready, 1);
`ifdef FSM_CMD_TX_STATS_EN
        check("ill_err_cnt", err_cnt, 1);
`endif
        step();
        check("ill_err_pulse_end", err_op, 0);

        // TOGGLE: single header, one cycle after acceptance, no busy.
        req_valid = 1'b1; req_op = 4'd2; req_voices = 8'h01;
        step();
        req_valid = 1'b0;
        exp_frames++;
        check("tog_valid", cmd_data_valid, 1);
        check("tog_data", cmd_data, 32'h2010_0000);
        check("tog_busy", busy, 0);
        check("tog_req_ready", req_ready, 1);
        step();
        check("tog_valid_not_held", cmd_data_valid, 0);

        // SET_FREQ with payload 1..6 back to back, then a refused 7th word.
        req_valid = 1'b1; req_op = 4'd3; req_voices = 8'h3F;
        step();
        req_valid = 1'b0;
        exp_frames++;
        check("freq_hdr_valid", cmd_data_valid, 1);
        check("freq_hdr", cmd_data, 32'h33F0_0000);
        check("freq_busy", busy, 1);
        for (int k = 1; k <= 6; k++) begin
            pay_valid = 1'b1;
            pay_data  = 32'(k);
            check($sformatf("freq_pay_ready%0d", k), pay_ready, 1);
            step();
            check($sformatf("freq_word%0d_valid", k), cmd_data_valid, 1);
            check($sformatf("freq_word%0d", k), cmd_data, 32'(k));
            check($sformatf("freq_req_ready%0d", k), req_ready, (k == 6) ? 1 : 0);
        end
        pay_data = 32'd7;
        check("freq_7th_pay_ready", pay_ready, 0);
        step();
        pay_valid = 1'b0;
        check("freq_7th_valid", cmd_data_valid, 0);
        check("freq_hold", cmd_data, 32'd6);

        foreach (vecs[i]) begin
            got_q.delete();
            exp_q.delete();
            err_seen = 0;
            run_frame(vecs[i].op, vecs[i].voices, vecs[i].stall);
            repeat (2) step();
            check($sformatf("vec%0d_count", i), got_q.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0)
                check($sformatf("vec%0d_hdr", i), (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF,
                      vecs[i].exp_hdr);
            check($sformatf("vec%0d_stream", i), stream_diff(), 0);
            check($sformatf("vec%0d_err", i), err_seen, vecs[i].exp_err);
            check($sformatf("vec%0d_idle", i), req_ready, 1);
        end

        got_q.delete();
        exp_q.delete();
        err_seen = 0;
        errs0 = exp_errs;
        for (int k = 0; k < 30; k++) begin
            r  = $urandom_range(0, 5);
            op = (r < 4) ? 4'(r) : 4'(4 + $urandom_range(0, 11));
            run_frame(op, 8'($urandom), 1'b1);
            if ($urandom_range(0, 1) == 1) step();
        end
        repeat (2) step();
        check("rand_count", got_q.size(), exp_q.size());
        check("rand_stream", stream_diff(), 0);
        check("rand_errs", err_seen, exp_errs - errs0);
`ifdef FSM_CMD_TX_STATS_EN
        check("stats_frame_cnt", frame_cnt, 32'(exp_frames));
        check("stats_err_cnt", err_cnt, (exp_errs > 255) ? 255 : exp_errs);
`endif

        // GAP_CYCLES=3 instance, TOGGLE offered continuously.
        g_req_valid = 1'b1; g_req_op = 4'd2; g_req_voices = 8'h01;
        low = 0;
        busy_gap = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (g_cmd_data_valid) hdr_cyc.push_back(c);
            if (c <= 4 && !g_req_ready) low++;
            if (c == 2) busy_gap = g_busy;
        end
        g_req_valid = 1'b0;
        check("gap_hdr_count", hdr_cyc.size(), 3);
        check("gap_spacing", (hdr_cyc.size() >= 2) ? hdr_cyc[1] - hdr_cyc[0] : -1, 4);
        check("gap_ready_low", low, 3);
        check("gap_busy", busy_gap, 1);
        check("gap_hdr_data", g_cmd_data, 32'h2010_0000);

        // Reset after the 10th SET payload word.
        send_req(4'd1, 8'h0F);
        pay_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            pay_data = 32'hC000_0000 + 32'(k);
            step();
        end
        check("mid_pre_valid", cmd_data_valid, 1);
        check("mid_pre_data", cmd_data, 32'hC000_000A);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", cmd_data_valid, 0);
        check("mid_rst_data", cmd_data, 0);
        check("mid_rst_busy", busy, 0);
        pay_valid = 1'b0;
        @(negedge clk147);
        rst_n = 1'b1;
        step();
        check("mid_rel_req_ready", req_ready, 1);
        check("mid_rel_pay_ready", pay_ready, 0);
        check("mid_rel_valid", cmd_data_valid, 0);
`ifdef FSM_CMD_TX_STATS_EN
        check("mid_rel_frame_cnt", frame_cnt, 0);
        check("mid_rel_err_cnt", err_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
